// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle shared by the timing generator and every Draw* stage.
// Latency: pure wiring; every signal is registered by whoever drives the bundle.
// Backpressure: none; consumers sample the raster free-running.
interface vga_timing_gen_if;
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       pixel_tick;
  logic       line_tick;
  logic       frame_tick;

  modport master (
    output h_counter, v_counter, hsync, vsync, video_on,
           pixel_tick, line_tick, frame_tick
  );

  modport slave (
    input  h_counter, v_counter, hsync, vsync, video_on,
           pixel_tick, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock divider, H/V pixel counters, registered syncs and ticks.
// Latency: syncs/VideoOn/ticks change in the same clock as the counters (zero skew).
// Backpressure: none; the raster free-runs and cannot be stalled.
module vga_timing_gen #(
  parameter int CLK_DIV     = 2,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 783,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 514
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  vga_timing_gen_if.master      o_vga
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYN_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYN_W  = 10'(V_SYNC);
  localparam logic [9:0] H_AS_W   = 10'(H_ACT_START);
  localparam logic [9:0] H_AE_W   = 10'(H_ACT_END);
  localparam logic [9:0] V_AS_W   = 10'(V_ACT_START);
  localparam logic [9:0] V_AE_W   = 10'(V_ACT_END);

  logic [3:0] r_div;
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_pix_tick;
  logic       r_line_tick;
  logic       r_frame_tick;

  logic       w_adv;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [3:0] w_div_nxt;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;

  // Next divider/counter values; syncs are derived from these so they line up with the counters.
  always_comb begin
    w_adv     = (r_div == DIV_LAST);
    w_h_wrap  = w_adv && (r_hcnt == H_LAST);
    w_v_wrap  = w_h_wrap && (r_vcnt == V_LAST);
    w_div_nxt = w_adv ? 4'd0 : r_div + 4'd1;
    w_h_nxt   = r_hcnt;
    w_v_nxt   = r_vcnt;
    if (w_adv) begin
      w_h_nxt = w_h_wrap ? 10'd0 : r_hcnt + 10'd1;
      if (w_h_wrap) begin
        w_v_nxt = w_v_wrap ? 10'd0 : r_vcnt + 10'd1;
      end
    end
  end

  // Raster state; reset drops everything at once so no partial line survives.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div        <= 4'd0;
      r_hcnt       <= 10'd0;
      r_vcnt       <= 10'd0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_video_on   <= 1'b0;
      r_pix_tick   <= 1'b0;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_div        <= w_div_nxt;
      r_hcnt       <= w_h_nxt;
      r_vcnt       <= w_v_nxt;
      r_hsync      <= (w_h_nxt >= H_SYN_W);
      r_vsync      <= (w_v_nxt >= V_SYN_W);
      r_video_on   <= (w_h_nxt >= H_AS_W) && (w_h_nxt <= H_AE_W) &&
                      (w_v_nxt >= V_AS_W) && (w_v_nxt <= V_AE_W);
      r_pix_tick   <= w_adv;
      r_line_tick  <= w_h_wrap;
      r_frame_tick <= w_v_wrap;
    end
  end

  assign o_vga.h_counter  = r_hcnt;
  assign o_vga.v_counter  = r_vcnt;
  assign o_vga.hsync      = r_hsync;
  assign o_vga.vsync      = r_vsync;
  assign o_vga.video_on   = r_video_on;
  assign o_vga.pixel_tick = r_pix_tick;
  assign o_vga.line_tick  = r_line_tick;
  assign o_vga.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small raster /2, small raster /1, full VGA /2).
// Latency: expectations are queued before each edge and compared 1 time unit after it.
// Backpressure: none; the raster free-runs.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       lt;
    logic       ft;
  } exp_t;

  // Per-instance timing: 0 = small /2, 1 = small /1, 2 = full VGA /2
  localparam int DIV [3] = '{2, 1, 2};
  localparam int HT  [3] = '{40, 40, 800};
  localparam int HS  [3] = '{6, 6, 96};
  localparam int HAS [3] = '{10, 10, 144};
  localparam int HAE [3] = '{33, 33, 783};
  localparam int VT  [3] = '{20, 20, 525};
  localparam int VS  [3] = '{2, 2, 2};
  localparam int VAS [3] = '{4, 4, 35};
  localparam int VAE [3] = '{17, 17, 514};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  always #5 clk = ~clk;

  vga_timing_gen_if ifa();
  vga_timing_gen_if ifb();
  vga_timing_gen_if ifc();

  vga_timing_gen #(.CLK_DIV(2), .H_TOTAL(40), .H_SYNC(6), .H_ACT_START(10), .H_ACT_END(33),
                   .V_TOTAL(20), .V_SYNC(2), .V_ACT_START(4), .V_ACT_END(17))
    dut_a (.i_clk(clk), .i_rst(rst), .o_vga(ifa));
  vga_timing_gen #(.CLK_DIV(1), .H_TOTAL(40), .H_SYNC(6), .H_ACT_START(10), .H_ACT_END(33),
                   .V_TOTAL(20), .V_SYNC(2), .V_ACT_START(4), .V_ACT_END(17))
    dut_b (.i_clk(clk), .i_rst(rst), .o_vga(ifb));
  vga_timing_gen #(.CLK_DIV(2))
    dut_c (.i_clk(clk), .i_rst(rst), .o_vga(ifc));

  // Reference: absolute pixel index from clock edges since release, then split into (h,v).
  function automatic exp_t model(int nn, int k);
    exp_t e;
    int p, h, v;
    p = nn / DIV[k];
    h = p % HT[k];
    v = (p / HT[k]) % VT[k];
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.hs  = (h >= HS[k]);
    e.vs  = (v >= VS[k]);
    e.von = (h >= HAS[k]) && (h <= HAE[k]) && (v >= VAS[k]) && (v <= VAE[k]);
    e.pt  = (nn >= 1) && (nn % DIV[k] == 0);
    e.lt  = e.pt && (h == 0);
    e.ft  = e.lt && (v == 0);
    return e;
  endfunction

  function automatic exp_t obs(int k);
    exp_t o;
    case (k)
      0: o = {ifa.h_counter, ifa.v_counter, ifa.hsync, ifa.vsync, ifa.video_on,
              ifa.pixel_tick, ifa.line_tick, ifa.frame_tick};
      1: o = {ifb.h_counter, ifb.v_counter, ifb.hsync, ifb.vsync, ifb.video_on,
              ifb.pixel_tick, ifb.line_tick, ifb.frame_tick};
      default: o = {ifc.h_counter, ifc.v_counter, ifc.hsync, ifc.vsync, ifc.video_on,
                    ifc.pixel_tick, ifc.line_tick, ifc.frame_tick};
    endcase
    return o;
  endfunction

  function automatic exp_t pop_exp(int k);
    exp_t e;
    case (k)
      0: e = qa.pop_front();
      1: e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
    return e;
  endfunction

  // Queue the expected post-edge state of every instance, then take one clock edge.
  task automatic advance();
    if (rst) n = 0;
    else     n = n + 1;
    qa.push_back(model(n, 0));
    qb.push_back(model(n, 1));
    qc.push_back(model(n, 2));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    for (int c = 0; c < 3; c++) begin
      advance();
      for (int k = 0; k < 3; k++) begin
        e = pop_exp(k); o = obs(k);
        n_assert++;
        if (o !== e || o !== '0) begin
          n_fail++;
          $display("FAIL reset dut%0d got=%h required=%h", k, o, e);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_pixel_seq();
    logic [9:0] hseq [8];
    logic       pseq [8];
    exp_t e, o;
    hseq = '{10'd0, 10'd1, 10'd1, 10'd2, 10'd2, 10'd3, 10'd3, 10'd4};
    pseq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 8; c++) begin
      advance();
      for (int k = 0; k < 3; k++) begin
        e = pop_exp(k); o = obs(k);
        n_assert++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL pixel_seq_sb dut%0d n=%0d got=%h required=%h", k, n, o, e);
        end
      end
      o = obs(0);
      n_assert++;
      if (o.h !== hseq[c] || o.pt !== pseq[c] || o.v !== 10'd0) begin
        n_fail++;
        $display("FAIL pixel_seq_div2 n=%0d got h=%0d v=%0d pt=%b required h=%0d v=0 pt=%b",
                 n, o.h, o.v, o.pt, hseq[c], pseq[c]);
      end
      o = obs(1);
      n_assert++;
      if (o.h !== 10'(c + 1) || o.pt !== 1'b1) begin
        n_fail++;
        $display("FAIL pixel_seq_div1 n=%0d got h=%0d pt=%b required h=%0d pt=1",
                 n, o.h, o.pt, c + 1);
      end
    end
  endtask

  task automatic test_hsync_line();
    exp_t e, o, prev;
    bit seen_hs = 0, seen_lt = 0, chk_lt_low = 0;
    prev = obs(2);
    for (int c = 0; c < 1600; c++) begin
      advance();
      for (int k = 0; k < 3; k++) begin
        e = pop_exp(k); o = obs(k);
        n_assert++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL line_sb dut%0d n=%0d got=%h required=%h", k, n, o, e);
        end
      end
      o = obs(2);
      if (chk_lt_low) begin
        chk_lt_low = 0;
        n_assert++;
        if (o.lt !== 1'b0) begin
          n_fail++;
          $display("FAIL line_tick_width got=%b required=0", o.lt);
        end
      end
      if (o.h == 10'd96 && prev.h == 10'd95) begin
        seen_hs = 1;
        n_assert++;
        if (prev.hs !== 1'b0 || o.hs !== 1'b1) begin
          n_fail++;
          $display("FAIL hsync_edge got %b->%b required 0->1", prev.hs, o.hs);
        end
      end
      if (o.h == 10'd0 && prev.h == 10'd799) begin
        seen_lt = 1;
        chk_lt_low = 1;
        n_assert++;
        if (o.lt !== 1'b1 || o.v !== 10'd1 || o.ft !== 1'b0) begin
          n_fail++;
          $display("FAIL line_wrap got lt=%b v=%0d ft=%b required lt=1 v=1 ft=0", o.lt, o.v, o.ft);
        end
      end
      prev = o;
    end
    n_assert++;
    if (!seen_hs || !seen_lt || chk_lt_low) begin
      n_fail++;
      $display("FAIL line_events_timeout got hs=%b lt=%b required both seen", seen_hs, seen_lt);
    end
  endtask

  task automatic test_window();
    int  th [6];
    int  tv [6];
    bit  tvon [6];
    bit  found;
    exp_t e, o;
    th   = '{10, 9, 10, 34, 33, 10};
    tv   = '{3, 4, 4, 4, 17, 18};
    tvon = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 6; t++) begin
      found = 0;
      for (int c = 0; c < 1700 && !found; c++) begin
        advance();
        for (int k = 0; k < 3; k++) begin
          e = pop_exp(k); o = obs(k);
          n_assert++;
          if (o !== e) begin
            n_fail++;
            $display("FAIL window_sb dut%0d n=%0d got=%h required=%h", k, n, o, e);
          end
        end
        o = obs(0);
        if (o.h == 10'(th[t]) && o.v == 10'(tv[t])) begin
          found = 1;
          n_assert++;
          if (o.von !== tvon[t]) begin
            n_fail++;
            $display("FAIL window (%0d,%0d) got von=%b required %b", th[t], tv[t], o.von, tvon[t]);
          end
        end
      end
      if (!found) begin
        n_assert++;
        n_fail++;
        $display("FAIL window_timeout (%0d,%0d) got not reached required reached", th[t], tv[t]);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    exp_t e, o;
    for (int c = 0; c < 1700 && !found; c++) begin
      advance();
      for (int k = 0; k < 3; k++) begin
        e = pop_exp(k); o = obs(k);
        n_assert++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL midreset_sb dut%0d n=%0d got=%h required=%h", k, n, o, e);
        end
      end
      o = obs(0);
      if (o.h == 10'd20 && o.v == 10'd10 && o.pt == 1'b0) found = 1;
    end
    n_assert++;
    if (!found) begin
      n_fail++;
      $display("FAIL midreset_timeout got (20,10) not reached required reached");
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      n_assert++;
      if (o !== '0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d got=%h required=0", k, o);
      end
    end
    for (int c = 0; c < 2; c++) begin
      advance();
      for (int k = 0; k < 3; k++) begin
        e = pop_exp(k); o = obs(k);
        n_assert++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL held_reset dut%0d got=%h required=%h", k, o, e);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int a_pt = 0, a_lt = 0, a_ft = 0, a_vsl = 0, a_vid = 0;
    int b_pt = 0, b_lt = 0, b_ft = 0, b_vid = 0, b_ft_dbl = 0;
    bit b_prev_ft = 0;
    exp_t e, o;
    for (int c = 0; c < 1600; c++) begin
      advance();
      for (int k = 0; k < 3; k++) begin
        e = pop_exp(k); o = obs(k);
        n_assert++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL frame_sb dut%0d n=%0d got=%h required=%h", k, n, o, e);
        end
      end
      o = obs(0);
      a_pt += int'(o.pt); a_lt += int'(o.lt); a_ft += int'(o.ft);
      a_vsl += int'(!o.vs); a_vid += int'(o.von && o.pt);
      o = obs(1);
      b_pt += int'(o.pt); b_lt += int'(o.lt); b_ft += int'(o.ft); b_vid += int'(o.von);
      if (o.ft && b_prev_ft) b_ft_dbl++;
      b_prev_ft = o.ft;
    end
    n_assert++;
    if (a_pt != 800 || a_lt != 20 || a_ft != 1) begin
      n_fail++;
      $display("FAIL frame_ticks_div2 got pt=%0d lt=%0d ft=%0d required 800/20/1", a_pt, a_lt, a_ft);
    end
    n_assert++;
    if (a_vsl != 160) begin
      n_fail++;
      $display("FAIL frame_vsync_low got=%0d required=160", a_vsl);
    end
    n_assert++;
    if (a_vid != 336) begin
      n_fail++;
      $display("FAIL frame_video_pixels got=%0d required=336", a_vid);
    end
    n_assert++;
    if (b_pt != 1600 || b_lt != 40 || b_ft != 2 || b_ft_dbl != 0) begin
      n_fail++;
      $display("FAIL frame_ticks_div1 got pt=%0d lt=%0d ft=%0d dbl=%0d required 1600/40/2/0",
               b_pt, b_lt, b_ft, b_ft_dbl);
    end
    n_assert++;
    if (b_vid != 672) begin
      n_fail++;
      $display("FAIL frame_video_div1 got=%0d required=672", b_vid);
    end
  endtask

  initial begin
    test_reset();
    test_pixel_seq();
    test_hsync_line();
    test_window();
    test_mid_reset();
    test_full_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA 640x480@60 Hz raster timing for the display pipeline. Divides the board clock down to the pixel rate, maintains the horizontal/vertical pixel counters consumed by all Draw* shape stages, and produces registered HSync, VSync and VideoOn. Counter convention: sync pulse first, then back porch, active area, front porch. Active region is H 144..783, V 35..514, so every downstream stage compares directly against raw counter values.

Parameters:
CLK_DIV, 2, board clocks per pixel (1..15); 2 gives 25 MHz pixels from 50 MHz
H_TOTAL, 800, clocks-per-line in pixels (counter wraps at H_TOTAL-1)
H_SYNC, 96, HSync low for HCounter 0..H_SYNC-1
H_ACT_START, 144, first active column
H_ACT_END, 783, last active column (inclusive)
V_TOTAL, 525, lines per frame (counter wraps at V_TOTAL-1)
V_SYNC, 2, VSync low for VCounter 0..V_SYNC-1
V_ACT_START, 35, first active line
V_ACT_END, 514, last active line (inclusive)

Ports:
Clk  in  1  board clock
Reset  in  1  asynchronous, active-high reset
HCounter  out  10  current pixel column, 0..H_TOTAL-1
VCounter  out  10  current line, 0..V_TOTAL-1
HSync  out  1  horizontal sync, active low
VSync  out  1  vertical sync, active low
VideoOn  out  1  high when HCounter and VCounter both inside active range (inclusive bounds)
PixelTick  out  1  one-Clk pulse marking each pixel advance
LineTick  out  1  one-Clk pulse coincident with HCounter wrapping to 0
FrameTick  out  1  one-Clk pulse coincident with both counters wrapping to 0

Behaviour:
- Reset: asynchronous assert, synchronous release; divider=0, HCounter=0, VCounter=0, HSync=0, VSync=0, VideoOn=0, PixelTick=0, LineTick=0, FrameTick=0. Reset mid-frame returns immediately to these values; no partial line completed.
- Divider: counts 0..CLK_DIV-1, wraps to 0. PixelTick registered, high for exactly one Clk when divider equals CLK_DIV-1. CLK_DIV=1: PixelTick constantly high after reset release.
- Counter advance on PixelTick only: HCounter+1; at H_TOTAL-1 wraps to 0 and VCounter+1; VCounter at V_TOTAL-1 wraps to 0. Counters hold between ticks.
- LineTick and FrameTick: registered, asserted in the same Clk cycle the counters take their wrapped value (HCounter=0; and VCounter=0 for FrameTick). FrameTick implies LineTick. Both are single-cycle regardless of CLK_DIV.
- HSync, VSync, VideoOn: registered, computed from the next-state counter values, so they are cycle-aligned with HCounter/VCounter (zero relative latency). A downstream combinational stage sees the sync and counter values of the same pixel together.
- HSync=0 iff HCounter<H_SYNC; VSync=0 iff VCounter<V_SYNC; VideoOn=1 iff H_ACT_START<=HCounter<=H_ACT_END and V_ACT_START<=VCounter<=V_ACT_END.
- Width: counters 10-bit unsigned; parameter totals must be <=1024; no overflow path exists since wrap precedes 1023.
- First pixel after reset release: counters remain (0,0) for CLK_DIV Clk cycles, then advance to (1,0).

Test Plan:
- Reset release, CLK_DIV=2 -> PixelTick on every 2nd Clk; HCounter 0,0,1,1,2,...; HSync=0, VSync=0, VideoOn=0 at (0,0).
- Run to HCounter=95->96 -> HSync goes 0->1 in same cycle HCounter becomes 96; HCounter=799 next tick -> HCounter=0, VCounter+1, LineTick one Clk high.
- Scan one full frame -> exactly 800*525=420000 PixelTicks; exactly 525 LineTicks; one FrameTick at (799,524)->(0,0); VSync low only for VCounter 0..1.
- Check active window -> VideoOn high at (144,35), (783,514); low at (143,35), (784,35), (144,34), (144,515); 640*480=307200 VideoOn pixels per frame.
- Assert Reset at (400,200) mid-pixel -> all outputs zero asynchronously same cycle; after release, frame restarts from (0,0) with correct timing.
- CLK_DIV=1 -> PixelTick constant 1; full frame in 420000 Clk cycles; FrameTick still single-cycle.
